quant_rr_scheduler: RTL and testbench
=====================================

// Module: quant_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one INT8 quantizer (fixed Q_LATENCY, no stall, no valid) among
//  NUM_REQ requesters in the AugmentMemory ML path. Grants bursts, drives the quantizer input,
//  tracks in-flight beats with a tag shift line, and routes each quantized result back to its owner.
// PARAMETERS
//  NUM_REQ       4   number of requesters (2..8)
//  INPUT_WIDTH   32  request data width
//  OUTPUT_WIDTH  8   quantized result width
//  Q_LATENCY     1   quantizer input-to-output latency in cycles (1..4)
//  MAX_BURST     4   max consecutive beats granted to one requester before rotation (1..15)
// PORTS
//  clk         in   1                    clock; all logic on posedge
//  rst         in   1                    synchronous active-high reset
//  req_valid   in   NUM_REQ              per-requester beat valid
//  req_data    in   NUM_REQ*INPUT_WIDTH  requester i data in bits [i*INPUT_WIDTH +: INPUT_WIDTH]
//  req_ready   out  NUM_REQ              one-hot (or 0) accept; beat transfers when valid&ready
//  flush       in   1                    end current burst, block new grants, drain in-flight beats
//  q_in_data   out  INPUT_WIDTH          to quantizer input
//  q_out_data  in   OUTPUT_WIDTH         from quantizer output, Q_LATENCY cycles after q_in_data
//  rsp_valid   out  NUM_REQ              one-hot result strobe, 1 cycle per beat
//  rsp_data    out  OUTPUT_WIDTH         quantized result, valid with rsp_valid
//  busy        out  1                    state != IDLE or any beat in flight
// BEHAVIOUR
//  Reset: req_ready=0, q_in_data=0, rsp_valid=0, rsp_data=0, busy=0, state=IDLE, rr pointer=0,
//   burst counter=0, tag line cleared. Reset mid-burst discards all in-flight beats (no rsp_valid).
//  States: IDLE, BURST, FLUSH.
//   IDLE: if flush=0 and any req_valid, pick first valid index searching from rr pointer upward
//    (wrapping); register grant; -> BURST next cycle. IDLE never asserts req_ready.
//   BURST: req_ready = onehot(grant) (combinational from registered grant). Each accepted beat
//    registers q_in_data <= req_data[grant] and pushes {1,grant} into the tag line; burst count +1.
//    Exit to IDLE, rr pointer <= grant+1 (mod NUM_REQ), when: count reaches MAX_BURST, or granted
//    req_valid=0 in a cycle (no beat taken that cycle). flush=1 has priority: -> FLUSH,
//    req_ready forced 0 that same cycle (no beat accepted).
//   FLUSH: req_ready=0; -> IDLE when tag line empty and flush=0.
//  Arbitration gap: one IDLE cycle between bursts; max throughput MAX_BURST beats per MAX_BURST+1
//   cycles.
//  q_in_data holds its last value when no beat is accepted (quantizer output then ignored).
//  Tag line: Q_LATENCY+1 stages (1 for q_in_data register, Q_LATENCY for quantizer). Stage 0
//   loaded on accept, else {0,x}. At last stage with valid=1: rsp_valid <= onehot(tag),
//   rsp_data <= q_out_data (registered; total accept-to-rsp latency = Q_LATENCY+2 cycles);
//   otherwise rsp_valid <= 0, rsp_data holds.
//  No backpressure on responses: rsp_valid is a strobe; owner must sink every beat.
//  Responses in acceptance order; beat count per requester conserved.
//  Simultaneous: flush in the cycle a burst would exit -> FLUSH wins; req_valid drop on final
//   MAX_BURST beat -> IDLE (both exits agree); rr pointer advances only on BURST exit or
//   flush-terminated burst.
//  Non-granted requesters never see req_ready; their valid/data must hold (standard valid/ready).
// TESTING
//  1 rst, req_valid=4'b0001, data=0x100, Q_LATENCY=1 -> q_in_data=0x100 next cycle; rsp_valid=0001
//    with quantizer result 3 cycles after accept; busy high throughout.
//  2 req_valid=4'b1111 held, MAX_BURST=4 -> grants 0,1,2,3,0 each exactly 4 beats, 1 idle
//    cycle between; 16 beats in 20 cycles.
//  3 req 2 sends 2 beats then drops valid -> burst ends after beat 2, next grant is req 3
//    (if valid) else wraps to 0.
//  4 flush pulse on 2nd beat of a burst -> that beat not accepted; 1 in-flight beat returned;
//    FLUSH held until flush=0 and line empty; then IDLE, rr pointer = grant+1.
//  5 rst asserted with 2 beats in flight -> no rsp_valid afterwards; all outputs at reset values
//    next cycle.
//  6 Random valid/data, 10k cycles, golden quantizer model -> per-requester rsp sequence equals
//    accepted sequence quantized, in order, none lost or duplicated.

Source files
------------

// File: rtl/quant_rr_scheduler.sv
// Round-robin scheduler that time-shares one fixed-latency INT8 quantizer between requesters,
// tracking in-flight beats with a tag shift line so every result returns to its owner.
module quant_rr_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 8,
    parameter int Q_LATENCY    = 1,
    parameter int MAX_BURST    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           flush,
    output logic [INPUT_WIDTH-1:0]         q_in_data,
    input  logic [OUTPUT_WIDTH-1:0]        q_out_data,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [OUTPUT_WIDTH-1:0]        rsp_data,
    output logic                           busy
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int STAGES = Q_LATENCY + 1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [INPUT_WIDTH-1:0]  q_in_data_q, q_in_data_d;
    logic [STAGES-1:0]       tag_vld_q, tag_vld_d;
    logic [IDX_W-1:0]        tag_idx_q [STAGES];
    logic [IDX_W-1:0]        tag_idx_d [STAGES];
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [OUTPUT_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick;
    int                      pick_idx;
    logic                    accept;
    logic [IDX_W-1:0]        next_rr;
    logic [INPUT_WIDTH-1:0]  granted_data;

    // First valid requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick       = rr_ptr_q;
        pick_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!pick_found && req_valid[pick_idx]) begin
                pick_found = 1'b1;
                pick       = IDX_W'(pick_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == BURST && !flush) begin
            req_ready[grant_q] = 1'b1;
        end
        accept       = req_ready[grant_q] & req_valid[grant_q];
        next_rr      = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        granted_data = req_data[int'(grant_q)*INPUT_WIDTH +: INPUT_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        q_in_data_d = q_in_data_q;
        case (state_q)
            IDLE: begin
                if (!flush && pick_found) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                // Flush outranks both normal exits; the pointer still moves past the victim.
                if (flush) begin
                    state_d     = FLUSH;
                    rr_ptr_d    = next_rr;
                    burst_cnt_d = '0;
                end else if (accept) begin
                    q_in_data_d = granted_data;
                    if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d     = IDLE;
                        rr_ptr_d    = next_rr;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    state_d     = IDLE;
                    rr_ptr_d    = next_rr;
                    burst_cnt_d = '0;
                end
            end
            FLUSH: begin
                if (!flush && !(|tag_vld_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag line mirrors the q_in_data register plus the quantizer pipeline depth.
    always_comb begin
        tag_vld_d[0] = accept;
        tag_idx_d[0] = grant_q;
        for (int k = 1; k < STAGES; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_idx_d[k] = tag_idx_q[k-1];
        end
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_vld_q[STAGES-1]) begin
            rsp_valid_d[tag_idx_q[STAGES-1]] = 1'b1;
            rsp_data_d                       = q_out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            q_in_data_q <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag_idx_q[k] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            q_in_data_q <= q_in_data_d;
            tag_vld_q   <= tag_vld_d;
            for (int k = 0; k < STAGES; k++) begin
                tag_idx_q[k] <= tag_idx_d[k];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign q_in_data = q_in_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE) || (|tag_vld_q);

endmodule

// File: tb/tb_quant_rr_scheduler.sv
// Directed and randomized self-checking bench for quant_rr_scheduler with a one-cycle quantizer model
// and a per-requester response scoreboard.
module tb_quant_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int IW      = 32;
    localparam int OW      = 8;
    localparam int QL      = 1;
    localparam int MB      = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    flush;
    logic [IW-1:0]           q_in_data;
    logic [OW-1:0]           q_out_data;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [OW-1:0]           rsp_data;
    logic                    busy;

    int checks = 0;
    int fails  = 0;

    logic [OW-1:0]      exp_q [NUM_REQ][$];
    int                 acc_cnt [NUM_REQ];
    int                 rsp_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] acc_now;
    logic [OW-1:0]      q_pipe;
    logic [OW-1:0]      exp_val;

    quant_rr_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .Q_LATENCY   (QL),
        .MAX_BURST   (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .flush      (flush),
        .q_in_data  (q_in_data),
        .q_out_data (q_out_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] quant(input logic [IW-1:0] x);
        return x[11:4] ^ x[23:16];
    endfunction

    // One-cycle quantizer model.
    always @(posedge clk) begin
        q_pipe <= quant(q_in_data);
    end
    assign q_out_data = q_pipe;

    // Scoreboard: record accepted beats and match every response strobe in order.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_q[i].delete();
                acc_cnt[i] = 0;
                rsp_cnt[i] = 0;
            end
            acc_now = '0;
        end else begin
            acc_now = req_valid & req_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_now[i]) begin
                    exp_q[i].push_back(quant(req_data[i*IW +: IW]));
                    acc_cnt[i] = acc_cnt[i] + 1;
                end
            end
            if (rsp_valid != '0) begin
                checks++;
                if ($countones(rsp_valid) != 1) begin
                    fails++;
                    $display("[TB] FAIL rsp_onehot: got %b, required exactly one bit", rsp_valid);
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (rsp_valid[i]) begin
                            rsp_cnt[i] = rsp_cnt[i] + 1;
                            if (exp_q[i].size() == 0) begin
                                fails++;
                                $display("[TB] FAIL rsp_unexpected: requester %0d got data %h, required no response", i, rsp_data);
                            end else begin
                                exp_val = exp_q[i].pop_front();
                                if (rsp_data !== exp_val) begin
                                    fails++;
                                    $display("[TB] FAIL rsp_data req%0d: got %h, required %h", i, rsp_data, exp_val);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        flush     = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        flush     = 1'b0;
        repeat (3) next_cycle();
        #1;
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ready: got %b, required 0000", req_ready); end
        checks++; if (q_in_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_q_in: got %h, required 0", q_in_data); end
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0000", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_rsp_data: got %h, required 00", rsp_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        next_cycle();
        rst       = 1'b0;
        req_valid = '0;
        next_cycle();
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_single_beat();
        $display("[TB] test_single_beat");
        do_reset();
        req_valid = 4'b0001;
        req_data[0*IW +: IW] = 32'h0000_0100;
        #1;
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL sb_idle_ready: got %b, required 0000", req_ready); end
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL sb_grant: got %b, required 0001", req_ready); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL sb_busy1: got %b, required 1", busy); end
        next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++; if (q_in_data !== 32'h0000_0100) begin fails++; $display("[TB] FAIL sb_q_in: got %h, required 00000100", q_in_data); end
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL sb_rsp_early1: got %b, required 0000", rsp_valid); end
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL sb_exit_ready: got %b, required 0000", req_ready); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL sb_busy_inflight: got %b, required 1", busy); end
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL sb_rsp_early2: got %b, required 0000", rsp_valid); end
        next_cycle(); #1;
        checks++; if (rsp_valid !== 4'b0001) begin fails++; $display("[TB] FAIL sb_rsp_valid: got %b, required 0001", rsp_valid); end
        checks++; if (rsp_data !== 8'h10) begin fails++; $display("[TB] FAIL sb_rsp_data: got %h, required 10", rsp_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL sb_busy_done: got %b, required 0", busy); end
        next_cycle(); #1;
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL sb_rsp_strobe: got %b, required 0000", rsp_valid); end
        checks++; if (rsp_data !== 8'h10) begin fails++; $display("[TB] FAIL sb_rsp_hold: got %h, required 10", rsp_data); end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_ready;
        int beats;
        $display("[TB] test_round_robin");
        do_reset();
        beats = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*IW +: IW] = 32'h0001_0000 * (i + 1) + 32'h10 * i;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) next_cycle();
            #1;
            exp_ready = '0;
            if (c % 5 != 0) exp_ready[(c / 5) % NUM_REQ] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                fails++;
                $display("[TB] FAIL rr_ready cycle %0d: got %b, required %b", c, req_ready, exp_ready);
            end
            if (c < 20 && (req_ready & req_valid) != '0) beats++;
        end
        checks++; if (beats != 16) begin fails++; $display("[TB] FAIL rr_beats_20cyc: got %0d, required 16", beats); end
        next_cycle();
        req_valid = '0;
        #2;
        checks++; if (acc_cnt[0] != 8) begin fails++; $display("[TB] FAIL rr_count0: got %0d, required 8", acc_cnt[0]); end
        checks++; if (acc_cnt[3] != 4) begin fails++; $display("[TB] FAIL rr_count3: got %0d, required 4", acc_cnt[3]); end
        drain(8);
    endtask

    task automatic test_drop_valid();
        $display("[TB] test_drop_valid");
        do_reset();
        req_data[2*IW +: IW] = 32'h0000_0200;
        req_data[3*IW +: IW] = 32'h0000_0300;
        req_data[0*IW +: IW] = 32'h0000_0010;
        req_valid = 4'b1100;
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL dv_grant2: got %b, required 0100", req_ready); end
        next_cycle();
        next_cycle();
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL dv_hold2: got %b, required 0100", req_ready); end
        checks++; if (q_in_data !== 32'h0000_0200) begin fails++; $display("[TB] FAIL dv_q_in: got %h, required 00000200", q_in_data); end
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL dv_gap: got %b, required 0000", req_ready); end
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b1000) begin fails++; $display("[TB] FAIL dv_next3: got %b, required 1000", req_ready); end
        checks++; if (acc_cnt[2] != 2) begin fails++; $display("[TB] FAIL dv_beats2: got %0d, required 2", acc_cnt[2]); end
        drain(8);

        do_reset();
        req_data[2*IW +: IW] = 32'h0000_0220;
        req_data[0*IW +: IW] = 32'h0000_0030;
        req_data[1*IW +: IW] = 32'h0000_0040;
        req_valid = 4'b0100;
        next_cycle();
        next_cycle();
        next_cycle();
        req_valid = 4'b0011;
        next_cycle();
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL dv_wrap0: got %b, required 0001", req_ready); end
        drain(8);
    endtask

    task automatic test_flush();
        $display("[TB] test_flush");
        do_reset();
        req_data[1*IW +: IW] = 32'h00AB_0CD0;
        req_data[2*IW +: IW] = 32'h0000_0450;
        req_data[0*IW +: IW] = 32'h0000_0560;
        req_valid = 4'b0010;
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0010) begin fails++; $display("[TB] FAIL fl_grant1: got %b, required 0010", req_ready); end
        next_cycle();
        flush = 1'b1;
        req_data[1*IW +: IW] = 32'h0011_2230;
        #1;
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL fl_ready_forced: got %b, required 0000", req_ready); end
        next_cycle(); #1;
        checks++; if (q_in_data !== 32'h00AB_0CD0) begin fails++; $display("[TB] FAIL fl_q_in_hold: got %h, required 00AB0CD0", q_in_data); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL fl_busy: got %b, required 1", busy); end
        next_cycle(); #1;
        checks++; if (rsp_valid !== 4'b0010) begin fails++; $display("[TB] FAIL fl_rsp_valid: got %b, required 0010", rsp_valid); end
        checks++; if (rsp_data !== 8'h66) begin fails++; $display("[TB] FAIL fl_rsp_data: got %h, required 66", rsp_data); end
        next_cycle();
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL fl_held: got %b, required 1", busy); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL fl_held_ready: got %b, required 0000", req_ready); end
        next_cycle();
        req_valid = 4'b0111;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL fl_idle: got %b, required 0", busy); end
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL fl_rr_next: got %b, required 0100", req_ready); end
        drain(8);
        checks++; if (acc_cnt[1] != 1) begin fails++; $display("[TB] FAIL fl_beats1: got %0d, required 1", acc_cnt[1]); end
    endtask

    task automatic test_reset_inflight();
        $display("[TB] test_reset_inflight");
        do_reset();
        req_data[0*IW +: IW] = 32'h0000_0AA0;
        req_valid = 4'b0001;
        next_cycle();
        next_cycle();
        req_data[0*IW +: IW] = 32'h0000_0BB0;
        next_cycle();
        rst       = 1'b1;
        req_valid = 4'b0000;
        next_cycle(); #1;
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL ri_ready: got %b, required 0000", req_ready); end
        checks++; if (q_in_data !== 32'h0) begin fails++; $display("[TB] FAIL ri_q_in: got %h, required 0", q_in_data); end
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL ri_rsp_valid: got %b, required 0000", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin fails++; $display("[TB] FAIL ri_rsp_data: got %h, required 00", rsp_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ri_busy: got %b, required 0", busy); end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); #1;
            checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL ri_quiet cycle %0d: got rsp_valid=%b busy=%b, required 0000/0", c, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int flush_left;
        int total;
        $display("[TB] test_back_to_back");
        do_reset();
        flush_left = 0;
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc_now[i]) begin
                    req_valid[i]          = ($urandom_range(0, 3) != 0);
                    req_data[i*IW +: IW]  = $urandom();
                end
            end
            if (flush_left > 0) begin
                flush_left--;
                flush = 1'b1;
            end else begin
                flush = 1'b0;
                if ($urandom_range(0, 79) == 0) flush_left = $urandom_range(1, 4);
            end
        end
        drain(12);
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            total += acc_cnt[i];
            checks++;
            if (rsp_cnt[i] != acc_cnt[i] || exp_q[i].size() != 0) begin
                fails++;
                $display("[TB] FAIL b2b_conserve req%0d: got %0d responses, required %0d", i, rsp_cnt[i], acc_cnt[i]);
            end
        end
        checks++;
        if (total < 1000) begin
            fails++;
            $display("[TB] FAIL b2b_progress: got %0d accepted beats, required at least 1000", total);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_drop_valid();
        test_flush();
        test_reset_inflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
